// File: rtl/bht_controller.sv
// Sequencing/update controller for a 2-bit saturating-counter branch history table.
// Sweeps the table to WEAKLY_NOT_TAKEN and applies queued branch outcomes by read-modify-write.
module bht_controller #(
    parameter int INDEX_WIDTH = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_req,
    input  logic                   upd_valid,
    input  logic [31:0]            upd_pc,
    input  logic                   upd_taken,
    output logic [INDEX_WIDTH-1:0] tbl_rd_index,
    input  logic [1:0]             tbl_rd_state,
    output logic                   tbl_we,
    output logic [INDEX_WIDTH-1:0] tbl_wr_index,
    output logic [1:0]             tbl_wr_state,
    output logic                   bht_ready,
    output logic                   flush_busy,
    output logic [15:0]            drop_cnt
);

    typedef enum logic [1:0] {
        STRONGLY_NOT_TAKEN = 2'b00,
        WEAKLY_NOT_TAKEN   = 2'b01,
        WEAKLY_TAKEN       = 2'b10,
        STRONGLY_TAKEN     = 2'b11
    } bht_state_t;

    typedef enum logic [1:0] {
        SWEEP = 2'b00,
        IDLE  = 2'b01,
        WRITE = 2'b10
    } state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]       PTR_ONE  = 1;
    localparam logic [PTR_W:0]         CNT_ONE  = 1;
    localparam logic [PTR_W:0]         CNT_FULL = FIFO_DEPTH;
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = 1;
    localparam logic [INDEX_WIDTH-1:0] IDX_LAST = {INDEX_WIDTH{1'b1}};

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
    logic [INDEX_WIDTH-1:0] op_index_q, op_index_d;
    logic                   op_taken_q, op_taken_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic [INDEX_WIDTH-1:0] fifo_idx_q [FIFO_DEPTH];
    logic                   fifo_tkn_q [FIFO_DEPTH];

    logic [INDEX_WIDTH-1:0] upd_index;
    logic [INDEX_WIDTH-1:0] head_index;
    logic                   head_taken;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop;
    logic                   push_req;
    logic                   push;
    logic                   drop;
    bht_state_t             rmw_state;

    assign upd_index  = upd_pc[2 +: INDEX_WIDTH];
    assign head_index = fifo_idx_q[rd_ptr_q];
    assign head_taken = fifo_tkn_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop      = (state_q == IDLE) && !fifo_empty && !flush_req;
    assign push_req = upd_valid && (state_q != SWEEP) && !flush_req;
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    always_comb begin
        rmw_state = bht_state_t'(tbl_rd_state);
        if (op_taken_q) begin
            if (tbl_rd_state != STRONGLY_TAKEN) begin
                rmw_state = bht_state_t'(tbl_rd_state + 2'd1);
            end
        end else begin
            if (tbl_rd_state != STRONGLY_NOT_TAKEN) begin
                rmw_state = bht_state_t'(tbl_rd_state - 2'd1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        op_index_d  = op_index_q;
        op_taken_d  = op_taken_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        drop_cnt_d  = drop_cnt_q;

        case (state_q)
            SWEEP: begin
                if (sweep_idx_q == IDX_LAST) begin
                    state_d     = IDLE;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + IDX_ONE;
                end
            end
            IDLE: begin
                if (pop) begin
                    op_index_d = head_index;
                    op_taken_d = head_taken;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = SWEEP;
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        // Flush wins over everything except the drop counter.
        if (flush_req) begin
            state_d     = SWEEP;
            sweep_idx_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
            op_index_q  <= '0;
            op_taken_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            op_index_q  <= op_index_d;
            op_taken_q  <= op_taken_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fifo_idx_q[gi] <= '0;
                    fifo_tkn_q[gi] <= 1'b0;
                end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    fifo_idx_q[gi] <= upd_index;
                    fifo_tkn_q[gi] <= upd_taken;
                end
            end
        end
    endgenerate

    // Table port outputs follow the current state; rst masks the write strobe immediately.
    always_comb begin
        tbl_we       = 1'b0;
        tbl_rd_index = '0;
        tbl_wr_index = '0;
        tbl_wr_state = WEAKLY_NOT_TAKEN;
        case (state_q)
            SWEEP: begin
                tbl_we       = !flush_req;
                tbl_wr_index = sweep_idx_q;
            end
            IDLE: begin
                if (pop) begin
                    tbl_rd_index = head_index;
                end
            end
            WRITE: begin
                tbl_we       = !flush_req;
                tbl_wr_index = op_index_q;
                tbl_wr_state = rmw_state;
            end
            default: begin
                tbl_we = 1'b0;
            end
        endcase
        if (rst) begin
            tbl_we = 1'b0;
        end
    end

    assign bht_ready  = (state_q != SWEEP);
    assign flush_busy = (state_q == SWEEP);
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_bht_controller.sv
// Directed bench for bht_controller with a registered-read table model and a write log.
module tb_bht_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [5:0]  tbl_rd_index;
    logic [1:0]  tbl_rd_state = 2'b00;
    logic        tbl_we;
    logic [5:0]  tbl_wr_index;
    logic [1:0]  tbl_wr_state;
    logic        bht_ready;
    logic        flush_busy;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic mon_en = 1'b0;

    logic [1:0] mem [64];

    typedef struct {
        int         c;
        logic [5:0] idx;
        logic [1:0] st;
    } wr_t;
    wr_t wq[$];

    bht_controller #(.INDEX_WIDTH(6), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_req    (flush_req),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .tbl_rd_index (tbl_rd_index),
        .tbl_rd_state (tbl_rd_state),
        .tbl_we       (tbl_we),
        .tbl_wr_index (tbl_wr_index),
        .tbl_wr_state (tbl_wr_state),
        .bht_ready    (bht_ready),
        .flush_busy   (flush_busy),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        tbl_rd_state <= mem[tbl_rd_index];
        if (tbl_we) mem[tbl_wr_index] <= tbl_wr_state;
    end

    always @(negedge clk) begin
        wr_t w;
        if (mon_en && tbl_we) begin
            w.c = cyc; w.idx = tbl_wr_index; w.st = tbl_wr_state;
            wq.push_back(w);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s got=%0h", tag, got);
        end else begin
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_check(input string tag);
        logic [31:0] e;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            e = {21'b0, 1'b1, 1'b0, 1'b1, 6'(i), 2'b01};
            check(tag, {21'b0, tbl_we, bht_ready, flush_busy, tbl_wr_index, tbl_wr_state}, e);
            next_cycle();
        end
        @(negedge clk);
        check({tag, "_done"}, {29'b0, tbl_we, bht_ready, flush_busy}, 32'b010);
        next_cycle();
    endtask

    task automatic pulse(input logic [31:0] pc, input logic tk);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk;
        next_cycle();
        upd_valid = 1'b0;
        next_cycle();
    endtask

    task automatic wait_writes(input string tag, input int n, input int limit);
        int k = 0;
        while (wq.size() < n && k < limit) begin
            next_cycle();
            k++;
        end
        check(tag, wq.size(), n);
    endtask

    task automatic expect_no_writes(input string tag, input int ncyc);
        wq.delete();
        mon_en = 1'b1;
        repeat (ncyc) next_cycle();
        check(tag, wq.size(), 0);
    endtask

    initial begin
        logic [1:0] sat_exp [7];
        int         acc [10];
        rst = 1'b1; flush_req = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        sat_exp = '{2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
        acc     = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we",       tbl_we, 0);
        check("rst_ready",    bht_ready, 0);
        check("rst_busy",     flush_busy, 1);
        check("rst_rd_index", tbl_rd_index, 0);
        check("rst_wr_index", tbl_wr_index, 0);
        check("rst_wr_state", tbl_wr_state, 1);
        check("rst_drop_cnt", drop_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        sweep_check("sweep0");
        expect_no_writes("sweep0_quiet", 3);
        mon_en = 1'b0;

        // single taken update to pc 0x10 -> index 4, 01 -> 10
        upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1;
        @(negedge clk); check("upd1_t0_we", tbl_we, 0);
        next_cycle(); upd_valid = 1'b0;
        @(negedge clk);
        check("upd1_t1_rd_index", tbl_rd_index, 4);
        check("upd1_t1_we", tbl_we, 0);
        next_cycle();
        @(negedge clk);
        check("upd1_t2_write", {29'b0, tbl_we, tbl_wr_index}, {25'b0, 1'b1, 6'd4});
        check("upd1_t2_state", tbl_wr_state, 2);
        next_cycle();

        // saturation up then floor down, updates spaced two cycles apart
        wq.delete(); mon_en = 1'b1;
        for (int i = 0; i < 3; i++) pulse(32'h10, 1'b1);
        for (int i = 0; i < 4; i++) pulse(32'h10, 1'b0);
        wait_writes("sat_nwrites", 7, 20);
        for (int i = 0; i < 7 && i < wq.size(); i++) begin
            check($sformatf("sat_w%0d", i), {wq[i].idx, wq[i].st}, {6'd4, sat_exp[i]});
        end
        mon_en = 1'b0;

        // back-to-back burst of 12: pushes 9 and 11 hit a full FIFO with no pop
        wq.delete(); mon_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            upd_valid = 1'b1; upd_pc = 32'(8 + i) << 2; upd_taken = (i % 2 == 0);
            next_cycle();
        end
        upd_valid = 1'b0;
        wait_writes("burst_nwrites", 10, 40);
        for (int k = 0; k < 10 && k < wq.size(); k++) begin
            check($sformatf("burst_w%0d", k), {wq[k].idx, wq[k].st},
                  {6'(8 + acc[k]), (acc[k] % 2 == 0) ? 2'd2 : 2'd0});
            if (k > 0) check($sformatf("burst_gap%0d", k), wq[k].c - wq[k-1].c, 2);
        end
        repeat (4) next_cycle();
        check("burst_total", wq.size(), 10);
        check("burst_drop_cnt", drop_cnt, 2);
        mon_en = 1'b0;

        // flush in a WRITE cycle with three updates queued
        wq.delete(); mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            upd_valid = 1'b1; upd_pc = 32'(32 + i) << 2; upd_taken = 1'b1;
            next_cycle();
        end
        upd_valid = 1'b0; flush_req = 1'b1;
        @(negedge clk);
        check("flush_we", tbl_we, 0);
        check("flush_prior_writes", wq.size(), 2);
        if (wq.size() >= 2) begin
            check("flush_prior_w0", {wq[0].idx, wq[0].st}, {6'd32, 2'd2});
            check("flush_prior_w1", {wq[1].idx, wq[1].st}, {6'd33, 2'd2});
        end
        mon_en = 1'b0;
        next_cycle(); flush_req = 1'b0;
        sweep_check("sweep1");
        expect_no_writes("flush_queue_discarded", 6);
        mon_en = 1'b0;

        // restart the sweep at index 20; an update during the sweep is ignored
        flush_req = 1'b1;
        next_cycle(); flush_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            upd_valid = (k == 5); upd_pc = 32'h10; upd_taken = 1'b1;
            @(negedge clk);
            if (k == 0 || k == 19) check($sformatf("sweep2_pre%0d", k), tbl_wr_index, k);
            next_cycle();
        end
        upd_valid = 1'b0; flush_req = 1'b1;
        @(negedge clk);
        check("sweep2_restart_at", {31'b0, bht_ready, tbl_wr_index}, {25'b0, 1'b0, 6'd20});
        next_cycle(); flush_req = 1'b0;
        sweep_check("sweep2");
        expect_no_writes("sweep2_update_discarded", 6);
        mon_en = 1'b0;
        check("drop_cnt_kept", drop_cnt, 2);

        // reset asserted in the WRITE cycle abandons the update
        upd_valid = 1'b1; upd_pc = 32'h14; upd_taken = 1'b1;
        next_cycle(); upd_valid = 1'b0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_we", tbl_we, 0);
        check("rst_mid_flags", {bht_ready, flush_busy}, 2'b01);
        check("rst_mid_drop_cnt", drop_cnt, 0);
        next_cycle();
        check("rst_mid_entry5", mem[5], 1);
        rst = 1'b0;
        sweep_check("sweep3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bht_controller.md
# bht_controller

Sequencing and update controller for the branch history table (BHT) of 2-bit saturating counters. It sits between the execute stage and a BHT storage array that has one synchronous-read/write port pair. It initialises or flushes every entry to WEAKLY_NOT_TAKEN and buffers resolved-branch outcomes in a small FIFO. It performs the read-modify-write counter update, and tells fetch when prediction data is valid.

## Interface
- INDEX_WIDTH, 6, BHT index bits; table has 2**INDEX_WIDTH entries; index = pc[2 +: INDEX_WIDTH]
- FIFO_DEPTH, 4, pending-update FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  reset, asynchronous, active-high
- flush_req  in  1  single-cycle pulse: invalidate whole BHT (context switch, fence.i)
- upd_valid  in  1  execute stage resolved a conditional branch this cycle
- upd_pc  in  32  PC of that branch
- upd_taken  in  1  resolved direction
- tbl_rd_index  out  INDEX_WIDTH  read address; data returned next cycle on tbl_rd_state
- tbl_rd_state  in  2  registered read data (bht_state_t)
- tbl_we  out  1  write enable
- tbl_wr_index  out  INDEX_WIDTH  write address
- tbl_wr_state  out  2  write data (bht_state_t)
- bht_ready  out  1  1 = table contents valid; fetch must predict not-taken when 0
- flush_busy  out  1  1 while sweeping
- drop_cnt  out  16  saturating count of updates lost to FIFO overflow

## Operation
- Encoding (bht_state_t): 00 STRONGLY_NOT_TAKEN, 01 WEAKLY_NOT_TAKEN, 10 WEAKLY_TAKEN, 11 STRONGLY_TAKEN. Prediction is bit 1.
- FSM states: SWEEP, IDLE, WRITE.
- SWEEP:
  - Counter sweep_idx drives tbl_we=1, tbl_wr_index=sweep_idx, tbl_wr_state=01, one entry per cycle.
  - After index 2**INDEX_WIDTH-1 is written, go to IDLE.
  - bht_ready=0, flush_busy=1.
  - Incoming updates are discarded and not counted as drops.
- IDLE:
  - If the FIFO is non-empty, pop the head into the op registers (index, taken) and drive tbl_rd_index=head index. Go to WRITE.
  - Otherwise stay in IDLE. tbl_we=0.
- WRITE:
  - tbl_we=1, tbl_wr_index=op index, tbl_wr_state=next(tbl_rd_state, op taken). Go to IDLE.
  - next() saturates: taken increments to a maximum of 11; not-taken decrements to a minimum of 00.
- Throughput: one update per 2 cycles. A read always follows the previous write by at least one edge, so back-to-back updates to the same index need no forwarding.
- FIFO push:
  - Condition: upd_valid && state!=SWEEP && !flush_req.
  - If the FIFO is full and no pop occurs this cycle, drop the update and increment drop_cnt, saturating at 0xFFFF.
  - If full and a pop occurs in the same cycle, accept the push.
  - Order is strictly FIFO.
- Flush: flush_req=1 in any state has these effects:
  - Suppresses any update write in that cycle (tbl_we=0 and no pop).
  - Empties the FIFO at the edge.
  - Sets state=SWEEP and sweep_idx=0 at the edge.
  - flush_req during SWEEP restarts the sweep at 0.
- drop_cnt is cleared only by rst.

## Timing
- Reset (rst high, asynchronous):
  - State: state=SWEEP, sweep_idx=0, FIFO empty, drop_cnt=0.
  - Outputs while rst=1: tbl_we=0, bht_ready=0, flush_busy=1, tbl_rd_index=0, tbl_wr_index=0, tbl_wr_state=01.
  - The first sweep write occurs in the first cycle after rst deasserts.
- Sweep length: exactly 2**INDEX_WIDTH cycles with tbl_we=1. bht_ready rises in the cycle after the last sweep write.
- Update latency:
  - Cycle t: upd_valid sampled.
  - Cycle t+1: IDLE pops and reads, if the FIFO was empty and the FSM is in IDLE.
  - Cycle t+2: WRITE, tbl_we=1.
  - Cycle t+3: the updated entry is readable.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Asserting rst mid-update abandons the update with no write.

## Test plan
- Reset release with INDEX_WIDTH=6 -> tbl_we=1 for 64 consecutive cycles with indices 0..63 and data 01; bht_ready=1 on cycle 65; no other writes.
- Single update pc=0x0000_0010, taken, entry=01 -> tbl_rd_index=4 at t+1; at t+2 tbl_we=1, index 4, data 10.
- Three taken updates to pc 0x10 spaced 2 cycles apart, starting at 10 -> writes 11, 11, 11 (saturation). Then three not-taken -> 10, 01, 00, 00 floor on a fourth.
- upd_valid every cycle for 12 cycles, FIFO_DEPTH=4 -> all writes in push order, 1 per 2 cycles; drop_cnt equals the number rejected while full with no pop, and that count is checked against a model.
- flush_req asserted in a WRITE cycle with 3 entries queued -> tbl_we=0 that cycle, FIFO empty, full 64-entry sweep follows, queued updates never written.
- flush_req re-asserted mid-sweep at sweep_idx=20 -> next write index 0; bht_ready stays 0 until 64 more sweep writes.
